// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer_if
// Description : Byte request / serial line bundle for the UART TX serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    // Upstream control / FIFO read side
    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  Busy
    );

    // Serializer side
    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output Busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : Shifts one byte out as start / data (LSB first) / parity / stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    uart_tx_serializer_if.slave  bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state_q,   w_state_d;
    logic [CNT_W-1:0]      r_cnt_q,     w_cnt_d;
    logic [DATA_WIDTH-1:0] r_data_q,    w_data_d;
    logic                  r_par_en_q,  w_par_en_d;
    logic                  r_par_bit_q, w_par_bit_d;
    logic                  r_tx_q,      w_tx_d;
    logic                  r_busy_q,    w_busy_d;
    logic                  w_accept;

    // A new byte may be taken only when the line is idle or finishing a stop bit.
    assign w_accept = bus.Data_Valid && ((r_state_q == S_IDLE) || (r_state_q == S_STOP));

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_data_d    = r_data_q;
        w_par_en_d  = r_par_en_q;
        w_par_bit_d = r_par_bit_q;

        case (r_state_q)
            S_IDLE, S_STOP: begin
                if (w_accept) begin
                    w_state_d   = S_START;
                    w_data_d    = bus.P_DATA;
                    w_par_en_d  = bus.PAR_EN;
                    w_par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
                end else begin
                    w_state_d   = S_IDLE;
                end
            end
            S_START: begin
                w_state_d = S_DATA;
                w_cnt_d   = '0;
            end
            S_DATA: begin
                if (r_cnt_q == c_last_cnt) begin
                    w_state_d = r_par_en_q ? S_PARITY : S_STOP;
                end else begin
                    w_cnt_d   = r_cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                w_state_d = S_STOP;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so TX_OUT comes straight off a flop.
    always_comb begin
        w_tx_d = 1'b1;
        case (w_state_d)
            S_START:  w_tx_d = 1'b0;
            S_DATA:   w_tx_d = w_data_d[w_cnt_d];
            S_PARITY: w_tx_d = w_par_bit_d;
            default:  w_tx_d = 1'b1;
        endcase
        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q   <= S_IDLE;
            r_cnt_q     <= '0;
            r_data_q    <= '0;
            r_par_en_q  <= 1'b0;
            r_par_bit_q <= 1'b0;
            r_tx_q      <= 1'b1;
            r_busy_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_data_q    <= w_data_d;
            r_par_en_q  <= w_par_en_d;
            r_par_bit_q <= w_par_bit_d;
            r_tx_q      <= w_tx_d;
            r_busy_q    <= w_busy_d;
        end
    end

    assign bus.TX_OUT = r_tx_q;
    assign bus.Busy   = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Directed stimulus with a per-bit expected-line scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    logic clk;
    logic rst;
    logic mon_en;
    int   n_checks;
    int   n_fail;
    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;

    uart_tx_serializer_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_serializer #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {TX_OUT, Busy} for every bit period of one frame.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
        exp_q.push_back(2'b01);
        for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b1});
        if (pe) exp_q.push_back({(^d) ^ pt, 1'b1});
        exp_q.push_back(2'b11);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Data_Valid = 1'b1;
        push_frame(d, pe, pt);
        cycles(1);
        bus.Data_Valid = 1'b0;
        bus.P_DATA     = ~d;
        bus.PAR_EN     = ~pe;
        bus.PAR_TYP    = ~pt;
    endtask

    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("frame_bit", 32'({bus.TX_OUT, bus.Busy}), 32'(mon_exp));
            end else begin
                check("idle_line", 32'({bus.TX_OUT, bus.Busy}), 32'(2'b10));
            end
        end
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        mon_en         = 1'b0;
        rst            = 1'b0;
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;

        cycles(2);
        check("reset_state", 32'({bus.TX_OUT, bus.Busy}), 32'(2'b10));
        rst    = 1'b1;
        mon_en = 1'b1;
        cycles(20);

        send(8'hA5, 1'b0, 1'b0);
        cycles(12);
        send(8'hA5, 1'b1, 1'b0);
        cycles(13);
        send(8'h01, 1'b1, 1'b1);
        cycles(13);

        // 0x3C, a 0xFF pulse mid-data, then 0x0F requested during the stop bit
        send(8'h3C, 1'b0, 1'b0);
        cycles(3);
        bus.P_DATA     = 8'hFF;
        bus.Data_Valid = 1'b1;
        cycles(1);
        bus.Data_Valid = 1'b0;
        cycles(5);
        send(8'h0F, 1'b0, 1'b0);
        cycles(13);

        // Reset during data bit 4 of 0x55
        send(8'h55, 1'b0, 1'b0);
        cycles(5);
        rst = 1'b0;
        #1;
        check("async_reset", 32'({bus.TX_OUT, bus.Busy}), 32'(2'b10));
        exp_q.delete();
        cycles(2);
        rst = 1'b1;
        cycles(2);
        send(8'h80, 1'b0, 1'b0);
        cycles(13);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit-side counterpart of the UART receive path: accepts one parallel byte plus framing configuration and shifts out a standard UART frame.
- Frame is start bit, 8 data bits LSB first, optional parity, then stop bit.
- Runs on the TX bit clock: one clk cycle equals one serial bit period.
- Sits between the system control/FIFO read side and the TX pad, and reports Busy so the upstream side can throttle.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- clk  input  1  TX bit clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  byte to transmit; sampled only on an accept edge.
- Data_Valid  input  1  single-cycle or level request to send P_DATA.
- PAR_EN  input  1  1 = insert parity bit; sampled on the accept edge.
- PAR_TYP  input  1  0 = even, 1 = odd parity; sampled on the accept edge.
- TX_OUT  output  1  serial line, registered; idles high.
- Busy  output  1  registered; high while a frame is in flight.

Behaviour:
- Reset (rst low, async):
  - state = IDLE; TX_OUT = 1; Busy = 0.
  - Data shift register, bit counter, latched PAR_EN/PAR_TYP and parity bit all = 0.
  - An in-progress frame is abandoned; the line returns high immediately.
- Accept edge:
  - A rising edge where Data_Valid = 1 and state is IDLE or STOP.
  - On it: latch P_DATA, PAR_EN and PAR_TYP; compute parity = ^P_DATA XOR PAR_TYP; go to START.
  - Data_Valid in any other state is ignored; no queueing.
- States (one clk per state per bit; outputs registered, valid the cycle after the edge that enters the state):
  - IDLE: TX_OUT = 1, Busy = 0. Accept edge -> START.
  - START: TX_OUT = 0, Busy = 1. Next edge -> DATA with counter = 0.
  - DATA: TX_OUT = data[counter], Busy = 1; counter increments each edge.
  - DATA exit: after counter = DATA_WIDTH-1 -> PARITY if latched PAR_EN = 1, else STOP.
  - PARITY: TX_OUT = latched parity bit, Busy = 1. Next edge -> STOP.
  - STOP: TX_OUT = 1, Busy = 1. Accept edge -> START (back-to-back, no idle gap, Busy stays 1); otherwise -> IDLE (Busy falls).
- Latency: TX_OUT falls to 0 on the first clk edge after the accept edge is sampled, i.e. one cycle.
- Frame length: 10 cycles with PAR_EN = 0, 11 cycles with PAR_EN = 1.
- Changes on P_DATA, PAR_EN or PAR_TYP during a frame have no effect on that frame.
- Counter width is clog2(DATA_WIDTH) and must not wrap into an extra data bit.
- TX_OUT is glitch-free: driven straight from a flop, with no combinational path from inputs.

Test Plan:
- Reset then idle: rst low, then high, with Data_Valid = 0 for 20 cycles -> TX_OUT = 1 and Busy = 0 throughout.
- No parity: P_DATA = 0xA5, PAR_EN = 0, one-cycle Data_Valid.
  - TX_OUT per cycle = 0,1,0,1,0,0,1,0,1,1.
  - Busy high for exactly 10 cycles, then 0.
- Even parity: P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0.
  - Parity cycle = 0; frame = 0,1,0,1,0,0,1,0,1,0,1 (11 cycles).
- Odd parity: P_DATA = 0x01, PAR_EN = 1, PAR_TYP = 1.
  - Parity bit = 0; frame = 0,1,0,0,0,0,0,0,0,0,1.
- Back-to-back and ignore-while-busy:
  - Setup: send 0x3C, pulse Data_Valid with 0xFF mid-DATA, then hold Data_Valid high with 0x0F during STOP.
  - 0xFF is never sent.
  - 0x0F start bit follows the 0x3C stop bit immediately; Busy never drops between the frames.
- Reset mid-frame: assert rst during DATA bit 4 of 0x55 -> TX_OUT = 1 and Busy = 0 asynchronously.
  - After release, the next accepted byte 0x80 produces a clean frame 0,0,0,0,0,0,0,0,1,1.
